// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   FETCH_DATA_WIDTH : default instruction/address width
//   FETCH_RESET_PC   : default PC after reset
//   PC_INC           : sequential PC step (one 32-bit instruction)
//   fetch_entry_t    : one instruction buffer entry {instr, pc}
package fetch_pkg;

    localparam int          FETCH_DATA_WIDTH = 32;
    localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [FETCH_DATA_WIDTH-1:0] instr;
        logic [FETCH_DATA_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response path and decode.
// Registered storage with no bypass: a word pushed in cycle N is visible
// at the head in cycle N+1.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   flush                 drop all entries this cycle (wins over push/pop)
//   push, push_instr/pc   write one entry
//   pop                   consume the head entry
//   head_valid            buffer not empty
//   head_instr/pc         head entry, zero when empty
//   count                 number of stored entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [FETCH_DATA_WIDTH-1:0] push_instr,
    input  logic [FETCH_DATA_WIDTH-1:0] push_pc,
    input  logic                        pop,
    output logic                        head_valid,
    output logic [FETCH_DATA_WIDTH-1:0] head_instr,
    output logic [FETCH_DATA_WIDTH-1:0] head_pc,
    output logic [CW-1:0]               count
);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !flush && (count != CW'(DEPTH));
    assign do_pop  = pop  && !flush && (count != '0);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr].instr <= push_instr;
            mem[wr_ptr].pc    <= push_pc;
        end
    end

    assign head_valid = (count != '0);
    assign head_instr = head_valid ? mem[rd_ptr].instr : '0;
    assign head_pc    = head_valid ? mem[rd_ptr].pc    : '0;

endmodule

// File: rtl/fetch_unit.sv
// Core front end: owns the PC, issues in-order fetch requests, buffers
// returned words and hands them to decode tagged with their PC.
// Downstream redirects reload the PC, flush the buffer and cause every
// still-outstanding response to be discarded on arrival.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   imem_req_valid/ready/addr         fetch request channel
//   imem_rsp_valid/data               in-order responses, always accepted
//   redirect_valid/pc                 control-flow redirect
//   instr_valid/ready, instr, instr_pc  head of buffer toward decode
//   pc_plus4                          instr_pc + 4 (wrapping)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [DATA_WIDTH-1:0] pc_plus4
);

    localparam int                    CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(PC_INC);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rsp_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         outstanding_next;
    logic [CW-1:0]         discard;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           in_use;
    logic                  req_fire;
    logic                  rsp_keep;
    logic                  pop;

    // Credit check: a request is only issued if a buffer slot is reserved
    // for its response, so the buffer can never overflow.
    assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = rst && !redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses for requests issued before a redirect are dropped, as is
    // any response arriving in the redirect cycle itself.
    assign rsp_keep = imem_rsp_valid && !redirect_valid && (discard == '0);
    assign pop      = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !imem_rsp_valid)
            outstanding_next = outstanding + CW'(1);
        else if (!req_fire && imem_rsp_valid)
            outstanding_next = outstanding - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc      <= redirect_pc;
                rsp_pc  <= redirect_pc;
                // Everything still in flight after this edge is stale.
                discard <= outstanding_next;
            end else begin
                if (req_fire)
                    pc <= pc + INC;
                if (imem_rsp_valid) begin
                    if (discard != '0)
                        discard <= discard - CW'(1);
                    else
                        rsp_pc <= rsp_pc + INC;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (rsp_keep),
        .push_instr (imem_rsp_data),
        .push_pc    (rsp_pc),
        .pop        (pop),
        .head_valid (instr_valid),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .count      (fifo_count)
    );

    assign pc_plus4 = instr_pc + INC;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-order memory model.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        redirect_valid, instr_valid, instr_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, instr_pc, pc_plus4;

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    typedef struct { logic [31:0] addr; int epoch; } pend_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; } exp_t;

    pend_t       pend_q[$];   // reference: requests in flight
    exp_t        exp_q[$];    // reference: expected buffer contents in order
    logic [31:0] mem_q[$];    // memory model: addresses awaiting a response
    int          epoch = 0;
    logic [31:0] mpc   = 32'h0;
    bit          checking = 1'b0;

    // Values sampled at the falling edge, applied at the next rising edge.
    logic        c_rst = 1'b0, c_acc = 1'b0, c_rsp = 1'b0, c_redir = 1'b0;
    logic [31:0] c_addr = '0, c_rpc = '0;

    int   p_ready, p_rsp, p_instr, p_redir;
    logic g_rst;

    // Monitor: samples away from the active edge and checks every pop.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rv;
        c_rst   = rst;
        c_acc   = imem_req_valid && imem_req_ready;
        c_addr  = imem_req_addr;
        c_rsp   = imem_rsp_valid;
        c_redir = redirect_valid;
        c_rpc   = redirect_pc;
        if (checking) begin
            exp_rv = rst && !redirect_valid && ((pend_q.size() + exp_q.size()) < DEPTH);
            chk("req_valid_credit", imem_req_valid === exp_rv, 32'(imem_req_valid), 32'(exp_rv));
            chk("instr_valid", instr_valid === (exp_q.size() != 0), 32'(instr_valid), 32'(exp_q.size() != 0));
            if (!instr_valid)
                chk("empty_head_zero", instr === 32'h0 && instr_pc === 32'h0, instr | instr_pc, 32'h0);
            if (rst && instr_valid && instr_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr", 1'b0, instr_pc, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_word", instr === e.word, instr, e.word);
                    chk("instr_pc", instr_pc === e.pc, instr_pc, e.pc);
                    chk("pc_plus4", pc_plus4 === e.pc + 32'd4, pc_plus4, e.pc + 32'd4);
                end
            end
        end
    end

    // Reference model: in-order fetch with epoch tagging for redirects.
    always @(posedge clk) begin
        pend_t p;
        exp_t  n;
        if (!c_rst) begin
            pend_q.delete();
            exp_q.delete();
            mpc = 32'h0;
        end else begin
            if (c_rsp && pend_q.size() > 0) begin
                p = pend_q.pop_front();
                if (!c_redir && p.epoch == epoch) begin
                    n.word = mem_word(p.addr);
                    n.pc   = p.addr;
                    exp_q.push_back(n);
                end
            end
            if (c_acc) begin
                chk("req_addr", c_addr === mpc, c_addr, mpc);
                p.addr  = c_addr;
                p.epoch = epoch;
                pend_q.push_back(p);
                mpc = mpc + 32'd4;
            end
            if (c_redir) begin
                epoch++;
                exp_q.delete();
                mpc = c_rpc;
            end
        end
    end

    // One clock: update the memory model, then drive new inputs.
    task automatic cycle();
        logic [31:0] tmp;
        @(posedge clk);
        if (!c_rst) mem_q.delete();
        else begin
            if (c_rsp && mem_q.size() > 0) tmp = mem_q.pop_front();
            if (c_acc) mem_q.push_back(c_addr);
        end
        #1;
        rst            = g_rst;
        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        imem_rsp_valid = g_rst && (mem_q.size() > 0) && ($urandom_range(0, 99) < p_rsp);
        imem_rsp_data  = (mem_q.size() > 0) ? mem_word(mem_q[0]) : $urandom;
        instr_ready    = ($urandom_range(0, 99) < p_instr);
        redirect_valid = g_rst && ($urandom_range(0, 99) < p_redir);
        redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; g_rst = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        p_ready = 100; p_rsp = 100; p_instr = 100; p_redir = 0;

        // Reset held three cycles with memory ready.
        for (int i = 0; i < 3; i++) begin
            cycle();
            checking = 1'b1;
            @(negedge clk);
            chk("rst_req_valid", imem_req_valid === 1'b0, 32'(imem_req_valid), 32'h0);
            chk("rst_instr_valid", instr_valid === 1'b0, 32'(instr_valid), 32'h0);
        end

        // Release: first requests at 0x0 then 0x4, then streaming.
        g_rst = 1'b1;
        cycle();
        @(negedge clk);
        chk("first_req", imem_req_valid === 1'b1 && imem_req_addr === 32'h0, imem_req_addr, 32'h0);
        cycle();
        @(negedge clk);
        chk("second_req", imem_req_valid === 1'b1 && imem_req_addr === 32'h4, imem_req_addr, 32'h4);
        run(12);

        // Mid-run reset, then decode backpressure fills the buffer.
        g_rst = 1'b0;
        run(2);
        g_rst = 1'b1; p_instr = 0;
        run(8);
        @(negedge clk);
        chk("bp_req_stall", imem_req_valid === 1'b0, 32'(imem_req_valid), 32'h0);
        chk("bp_pc_held", imem_req_addr === 32'h8, imem_req_addr, 32'h8);
        chk("bp_head_pc", instr_valid === 1'b1 && instr_pc === 32'h0, instr_pc, 32'h0);
        p_instr = 100;
        run(12);

        // Redirect with two requests outstanding.
        p_rsp = 0;
        run(5);
        @(negedge clk);
        chk("outstanding_stall", imem_req_valid === 1'b0, 32'(imem_req_valid), 32'h0);
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        p_rsp = 100;
        cycle();
        @(negedge clk);
        chk("redir_addr", imem_req_addr === 32'h0000_0100, imem_req_addr, 32'h0000_0100);
        run(12);

        // Wrap around the top of the address space.
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        @(negedge clk);
        chk("wrap_addr", imem_req_addr === 32'hFFFF_FFFC, imem_req_addr, 32'hFFFF_FFFC);
        run(12);

        // Randomized traffic with redirects and one reset.
        p_ready = 75; p_rsp = 60; p_instr = 70; p_redir = 6;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) g_rst = 1'b0;
            if (i == 1502) g_rst = 1'b1;
            cycle();
        end

        // Drain everything still in flight.
        p_redir = 0; p_ready = 0; p_rsp = 100; p_instr = 100;
        run(12);
        @(negedge clk);
        chk("drain_empty", instr_valid === 1'b0 && exp_q.size() == 0, 32'(instr_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
